// File: rtl/serial_subtractor_4b_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives start and the operands. The slave returns busy, done and the result.
interface serial_subtractor_4b_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borrow
   );
endinterface

// File: rtl/serial_subtractor_4b.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// It runs as a + ~b + ~bin through a single full-adder cell, so borrow is the inverse of the final carry.
module serial_subtractor_4b #(
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_subtractor_4b_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic             accept, last;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, diff_r;
   logic             c, borrow_r;
   logic [CW-1:0]    cnt;
   logic             s, co;

   // Full-adder cell shared with the parallel adder datapath.
   function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
      fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   always_comb begin
      {co, s} = fa(a_sr[0], ~b_sr[0], c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      last     = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            bus.busy = 1'b1;
            if (cnt == LAST) begin
               last    = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            // A start in the done cycle chains straight into the next operation.
            if (bus.start) begin
               accept  = 1'b1;
               state_n = SHIFT;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
      end else if (accept) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         res_sr <= '0;
         c      <= ~bus.bin;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {s, res_sr[WIDTH-1:1]};
         c      <= co;
         if (last) begin
            diff_r   <= {s, res_sr[WIDTH-1:1]};
            borrow_r <= ~co;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.diff   = diff_r;
   assign bus.borrow = borrow_r;
endmodule
